fp_alu_sequencer: RTL
=====================

FP_ALU_SEQUENCER -- requirements
Module: fp_alu_sequencer

Interface
REQ-001 The block SHALL have parameter SHORT_LAT, default 1: cycles the enable is held for add/sub/mul/max/min/eq/lt/leq (legal range 1-15).
REQ-002 The block SHALL have parameter LONG_LAT, default 8: cycles the enable is held for div/sqrt (legal range 1-15).
REQ-003 clk  input  1  sole clock; all state updates on posedge.
REQ-004 rst_n  input  1  synchronous, active-low reset.
REQ-005 in_valid  input  1  request present.
REQ-006 in_ready  output  1  request accepted when in_valid&&in_ready.
REQ-007 op  input  4  0=add,1=sub,2=mul,3=div,4=sqrt,5=max,6=min,7=eq,8=lt,9=leq; 10-15 illegal.
REQ-008 rs1_data, rs2_data  input  32 each  IEEE-754 single-precision operands.
REQ-009 rd  input  5  destination tag, returned unchanged with the result.
REQ-010 alu_a, alu_b  output  32 each  operands to the FP ALU, held stable for the whole operation.
REQ-011 alu_en  output  10  one-hot enables to the FP ALU, bit9..bit0 = add,sub,mul,div,sqrt,max,min,eq,lt,leq.
REQ-012 alu_result  input  32  registered FP ALU output.
REQ-013 out_valid  output  1  result available; out_ready  input  1  consumer accepts.
REQ-014 out_data  output  32; out_rd  output  5; out_err  output  1  illegal-op flag.

Function
REQ-015 FSM states SHALL be IDLE, EXEC, CAPT, DONE.
REQ-016 IDLE: in_ready=1, alu_en=0. On in_valid, latch op/operands/rd. Legal op -> EXEC with counter=LAT-1. Illegal op -> DONE with out_data=0.
REQ-017 EXEC: in_ready=0, alu_en = one-hot of latched op. If counter==0 -> CAPT, else decrement.
REQ-018 Each accepted legal op SHALL assert exactly one alu_en bit for exactly LAT consecutive cycles (SHORT_LAT or LONG_LAT per op).
REQ-019 CAPT: alu_en=0 for one cycle. At its closing edge, alu_result SHALL be registered into out_data. Then go to DONE.
REQ-020 DONE: out_valid=1. out_data/out_rd/out_err SHALL be stable until out_valid&&out_ready, then go to IDLE.
REQ-021 No request SHALL be accepted outside IDLE. Accept-to-out_valid latency SHALL be LAT+2 cycles for legal ops and 1 cycle for illegal ops.
REQ-022 alu_a/alu_b SHALL change only on acceptance.
REQ-023 If out_ready is already 1 when DONE is entered, the handshake SHALL complete in that cycle and the next request SHALL be accepted on the following cycle (IDLE).
REQ-024 out_rd SHALL equal the rd latched at acceptance.

Reset
REQ-025 While rst_n=0 at a posedge: state=IDLE, alu_en=0, out_valid=0, out_data=0, out_rd=0, out_err=0, alu_a=alu_b=0, counter=0.
REQ-026 Reset asserted in EXEC/CAPT/DONE SHALL abort the operation: no result is produced, and alu_en=0 from the next cycle.

Configuration
REQ-027 Macro FP_SEQ_ILLEGAL_TRAP_EN defined: an illegal op SHALL produce out_err=1 and out_data=0 through DONE.
REQ-028 FP_SEQ_ILLEGAL_TRAP_EN undefined: out_err SHALL be constant 0, and an illegal op SHALL still return out_data=0 through DONE as a silent no-op.

Verification
REQ-029 Add: op=0, rs1=32'h3F800000, rs2=32'h40000000, model ALU returns 32'h40400000, out_ready=1 -> alu_en=10'b1000000000 for 1 cycle, out_valid 3 cycles after accept, out_data=32'h40400000, out_err=0.
REQ-030 Div: op=3, rs1=32'h40C00000, rs2=32'h40000000, model returns 32'h40400000 -> alu_en=10'b0001000000 for 8 cycles, out_valid 10 cycles after accept, in_ready=0 throughout.
REQ-031 Backpressure: complete an op=7 (eq), rd=5'd17, with out_ready=0 for 5 cycles -> out_valid held, out_data/out_rd=17 stable, second in_valid ignored until IDLE.
REQ-032 Illegal: op=4'hC with FP_SEQ_ILLEGAL_TRAP_EN -> out_valid after 1 cycle, out_err=1, out_data=0, alu_en never nonzero. Without the macro -> out_err=0.
REQ-033 Reset abort: rst_n=0 during cycle 4 of a sqrt (op=4) -> next cycle state IDLE, alu_en=0, out_valid=0, in_ready=1, no spurious result.
REQ-034 Back-to-back: two add requests with out_ready=1 -> second accepted exactly 1 cycle after the first out_valid handshake, with one-hot alu_en checked every cycle.

Source files
------------

// File: rtl/fp_alu_sequencer.sv
// ---------------------------------------------------------------------------
// fp_alu_sequencer
//
// Accepts one floating-point request at a time, holds the operands and a
// one-hot enable on an external FP ALU for a fixed number of cycles, captures
// the ALU result and presents it with its destination tag until consumed.
//
// Operation codes: 0=add 1=sub 2=mul 3=div 4=sqrt 5=max 6=min 7=eq 8=lt 9=leq.
// Codes 10-15 are illegal. An illegal request never drives the ALU and returns
// out_data=0.
//
// Build option:
//   FP_SEQ_ILLEGAL_TRAP_EN  defined   -> illegal ops report out_err=1.
//                           undefined -> out_err is tied to 0 (silent no-op).
//
// Parameters:
//   SHORT_LAT  enable cycles for add/sub/mul/max/min/eq/lt/leq (1-15)
//   LONG_LAT   enable cycles for div/sqrt (1-15)
//
// Ports:
//   clk                 sole clock, rising edge
//   rst_n               synchronous active-low reset
//   in_valid/in_ready   request handshake (ready only when idle)
//   op, rs1_data,
//   rs2_data, rd        request fields
//   alu_a, alu_b        operands to the ALU, change only on acceptance
//   alu_en[9:0]         one-hot enable, bit9..bit0 = add..leq
//   alu_result          registered ALU output
//   out_valid/out_ready result handshake
//   out_data, out_rd,
//   out_err             result fields, stable while out_valid is held
// ---------------------------------------------------------------------------
module fp_alu_sequencer #(
    parameter int unsigned SHORT_LAT = 1,
    parameter int unsigned LONG_LAT  = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  op,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    input  logic [4:0]  rd,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [9:0]  alu_en,
    input  logic [31:0] alu_result,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [4:0]  out_rd,
    output logic        out_err
);

    // Counter preload values: the EXEC state lasts preload+1 cycles.
    localparam logic [3:0] SHORT_CNT = 4'(SHORT_LAT - 1);
    localparam logic [3:0] LONG_CNT  = 4'(LONG_LAT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        CAPT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state_reg, state_next;
    logic [3:0]  cnt_reg, cnt_next;
    logic [3:0]  op_reg;
    logic [31:0] alu_a_reg, alu_b_reg;
    logic [31:0] out_data_reg;
    logic [4:0]  out_rd_reg;
    logic [9:0]  en_decode;
    logic        accept;
    logic        op_legal;
    logic        op_long;

    assign accept   = in_valid && (state_reg == IDLE);
    assign op_legal = (op <= 4'd9);
    assign op_long  = (op == 4'd3) || (op == 4'd4);

    // Enable bit 9-k belongs to op code k (add on the MSB, leq on the LSB).
    genvar gi;
    generate
        for (gi = 0; gi < 10; gi++) begin : g_en_decode
            assign en_decode[gi] = (op_reg == 4'(9 - gi));
        end
    endgenerate

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= 4'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    if (op_legal) begin
                        state_next = EXEC;
                        cnt_next   = op_long ? LONG_CNT : SHORT_CNT;
                    end else begin
                        state_next = DONE;
                        cnt_next   = 4'd0;
                    end
                end
            end
            EXEC: begin
                if (cnt_reg == 4'd0) begin
                    state_next = CAPT;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            CAPT: begin
                state_next = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = 4'd0;
            end
        endcase
    end

    // Request latch and result capture. out_data is cleared on every accept
    // so an illegal request returns zero without a separate path.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            alu_a_reg    <= 32'd0;
            alu_b_reg    <= 32'd0;
            op_reg       <= 4'd0;
            out_rd_reg   <= 5'd0;
            out_data_reg <= 32'd0;
        end else if (accept) begin
            alu_a_reg    <= rs1_data;
            alu_b_reg    <= rs2_data;
            op_reg       <= op;
            out_rd_reg   <= rd;
            out_data_reg <= 32'd0;
        end else if (state_reg == CAPT) begin
            out_data_reg <= alu_result;
        end
    end

`ifdef FP_SEQ_ILLEGAL_TRAP_EN
    logic err_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_reg <= 1'b0;
        end else if (accept) begin
            err_reg <= !op_legal;
        end
    end

    assign out_err = err_reg;
`else
    assign out_err = 1'b0;
`endif

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == DONE);
    assign alu_en    = (state_reg == EXEC) ? en_decode : 10'd0;
    assign alu_a     = alu_a_reg;
    assign alu_b     = alu_b_reg;
    assign out_data  = out_data_reg;
    assign out_rd    = out_rd_reg;

endmodule
